// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver: parity-mode
//                encodings, receiver FSM state enumeration and a small
//                helper that decodes whether a parity bit is present.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity-mode encodings as presented on the parity input
    localparam logic [1:0] c_PARITY_NONE  = 2'b00;
    localparam logic [1:0] c_PARITY_ODD   = 2'b01;
    localparam logic [1:0] c_PARITY_EVEN  = 2'b10;
    localparam logic [1:0] c_PARITY_NONE2 = 2'b11;

    // Receiver FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } uart_state_e;

    // True when the frame carries a parity bit
    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == c_PARITY_ODD) || (mode == c_PARITY_EVEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Receive FIFO with power-of-two depth. Head word is presented
//                combinationally (zero when empty); a push into a full FIFO is
//                accepted only if a pop happens on the same edge, otherwise it
//                is dropped and a one-cycle overrun pulse follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,          // asynchronous, active-low
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_valid,
    output logic                     o_overrun,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               overrun_q, overrun_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_CNT_W'(DEPTH));
    assign w_pop   = i_ready && !w_empty;
    // A full FIFO still takes the word when the head leaves on the same edge
    assign w_wr    = i_push && (!w_full || w_pop);

    // Next-state for storage, pointers, occupancy and the overrun pulse
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = i_push && w_full && !w_pop;
        if (w_wr) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        case ({w_wr, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_head    = w_empty ? '0 : mem_q[rd_ptr_q];
    assign o_valid   = !w_empty;
    assign o_overrun = overrun_q;
    assign o_count   = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Synchronises rx, finds the start
//                bit on a falling edge, samples mid-bit with a programmable
//                tick divider, checks parity/stop and queues each received word
//                with its error flags into a small FIFO with RTS flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int MAX_BITS   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RTS_LEVEL  = FIFO_DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        rst,        // asynchronous, active-low
    input  logic [15:0]                 divisor,
    input  logic [$clog2(MAX_BITS):0]   nbits,
    input  logic [1:0]                  parity,
    input  logic                        rx,
    output logic [MAX_BITS-1:0]         data,
    output logic                        valid,
    input  logic                        ready,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        rts
);

    localparam int c_NB_W   = $clog2(MAX_BITS) + 1;
    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_WORD_W = MAX_BITS + 2;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_NB_W-1:0]   c_NB_MIN = c_NB_W'(5);
    localparam logic [c_NB_W-1:0]   c_NB_MAX = c_NB_W'(MAX_BITS);
    localparam logic [c_TICK_W-1:0] c_HALF   = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_FULL   = c_TICK_W'(OVERSAMPLE - 1);

    // Line synchroniser and edge history
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Frame state
    uart_state_e          state_q,      state_d;
    logic [15:0]          div_lat_q,    div_lat_d;
    logic [15:0]          div_cnt_q,    div_cnt_d;
    logic [c_NB_W-1:0]    nbits_lat_q,  nbits_lat_d;
    logic [1:0]           parity_lat_q, parity_lat_d;
    logic [c_TICK_W-1:0]  tick_cnt_q,   tick_cnt_d;
    logic [c_NB_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [MAX_BITS-1:0]  word_q,       word_d;
    logic                 par_acc_q,    par_acc_d;
    logic                 par_err_q,    par_err_d;

    logic                 w_fall;
    logic                 w_tick;
    logic                 w_push;
    logic                 w_frame_err;
    logic [c_NB_W-1:0]    w_nbits_res;
    logic [c_WORD_W-1:0]  w_push_word;
    logic [c_WORD_W-1:0]  w_head;
    logic                 w_valid;
    logic                 w_overrun;
    logic [c_CNT_W-1:0]   w_count;

    assign w_fall      = rx_prev_q && !rx_s2_q;
    assign w_tick      = (state_q != S_IDLE) && (div_cnt_q == 16'd0);
    assign w_nbits_res = ((nbits < c_NB_MIN) || (nbits > c_NB_MAX)) ? c_NB_MAX : nbits;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Tick divider: restarts from the live divisor at start detection, then
    // reloads from the latched copy each time it expires
    always_comb begin
        div_cnt_d = div_cnt_q;
        if ((state_q == S_IDLE) && w_fall) begin
            div_cnt_d = divisor;
        end else if (state_q != S_IDLE) begin
            div_cnt_d = (div_cnt_q == 16'd0) ? div_lat_q : div_cnt_q - 16'd1;
        end
    end

    // Receiver FSM next-state, sampling and push generation
    always_comb begin
        state_d      = state_q;
        div_lat_d    = div_lat_q;
        nbits_lat_d  = nbits_lat_q;
        parity_lat_d = parity_lat_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        word_d       = word_q;
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d      = S_START;
                    div_lat_d    = divisor;
                    nbits_lat_d  = w_nbits_res;
                    parity_lat_d = parity;
                    tick_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    word_d       = '0;
                    par_acc_d    = 1'b0;
                    par_err_d    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (tick_cnt_q == c_HALF) begin
                        tick_cnt_d = '0;
                        // Line back high at mid-start: treat as noise
                        state_d    = rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_TICK_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (tick_cnt_q == c_FULL) begin
                        tick_cnt_d = '0;
                        for (int i = 0; i < MAX_BITS; i++) begin
                            if (bit_cnt_q == c_NB_W'(i)) begin
                                word_d[i] = rx_s2_q;
                            end
                        end
                        par_acc_d = par_acc_q ^ rx_s2_q;
                        bit_cnt_d = bit_cnt_q + c_NB_W'(1);
                        if (bit_cnt_q == nbits_lat_q - c_NB_W'(1)) begin
                            state_d = parity_en(parity_lat_q) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_TICK_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    if (tick_cnt_q == c_FULL) begin
                        tick_cnt_d = '0;
                        par_err_d  = (parity_lat_q == c_PARITY_ODD) ?
                                     !(par_acc_q ^ rx_s2_q) : (par_acc_q ^ rx_s2_q);
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_TICK_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (tick_cnt_q == c_FULL) begin
                        tick_cnt_d  = '0;
                        w_push      = 1'b1;
                        w_frame_err = !rx_s2_q;
                        // A low stop bit that stays low is a line break
                        state_d     = rx_s2_q ? S_IDLE : S_BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + c_TICK_W'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            div_lat_q    <= '0;
            div_cnt_q    <= '0;
            nbits_lat_q  <= '0;
            parity_lat_q <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_lat_q    <= div_lat_d;
            div_cnt_q    <= div_cnt_d;
            nbits_lat_q  <= nbits_lat_d;
            parity_lat_q <= parity_lat_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
        end
    end

    // Word layout in the FIFO: {data, frame_err, parity_err}
    assign w_push_word = {word_q, w_frame_err, par_err_q};

    uart_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_word),
        .i_ready     (ready),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_overrun   (w_overrun),
        .o_count     (w_count)
    );

    assign data       = w_head[c_WORD_W-1:2];
    assign frame_err  = w_head[1];
    assign parity_err = w_head[0];
    assign valid      = w_valid;
    assign overrun    = w_overrun;
    assign rts        = (w_count < c_CNT_W'(RTS_LEVEL));

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (divisor 0, so one
//                sample tick per clk and 16 clks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int c_BIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] divisor;
    logic [3:0]  nbits;
    logic [1:0]  parity;
    logic        rx;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic        rts;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int ovr_cnt  = 0;
    int push_cnt = 0;
    logic valid_d1 = 1'b0;

    uart_rx #(
        .MAX_BITS   (8),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .divisor    (divisor),
        .nbits      (nbits),
        .parity     (parity),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .rts        (rts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitors sampled on the falling edge
    always @(negedge clk) begin
        if (valid === 1'b1 && valid_d1 !== 1'b1) rise_cyc = cyc;
        valid_d1 = valid;
        if (overrun === 1'b1) ovr_cnt++;
        if (dut.w_push === 1'b1) push_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds the line for one bit time
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, data}, {24'd0, exp});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int p0;
        int o0;
        bit found;

        rst = 1'b0; rx = 1'b1; ready = 1'b0;
        divisor = 16'd0; nbits = 4'd8; parity = c_PARITY_NONE;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_valid",      32'(valid),      32'd0);
        chk("rst_data",       32'(data),       32'd0);
        chk("rst_frame_err",  32'(frame_err),  32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_rts",        32'(rts),        32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5, 8N1. Valid rises 155 clks after the line drops:
        // 2 sync + 1 detect + 8 half-bit ticks + 9 bits * 16 ticks.
        start_cyc = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        chk("a5_latency", 32'(rise_cyc - start_cyc), 32'd155);
        chk("a5_valid",   32'(valid),      32'd1);
        chk("a5_ferr",    32'(frame_err),  32'd0);
        chk("a5_perr",    32'(parity_err), 32'd0);
        pop_expect("a5_data", 8'hA5);
        chk("a5_empty", 32'(valid), 32'd0);

        // 7 bits even parity, 0x41 has two ones
        nbits = 4'd7; parity = c_PARITY_EVEN;
        repeat (4) @(negedge clk);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        chk("par1_perr", 32'(parity_err), 32'd1);
        chk("par1_ferr", 32'(frame_err),  32'd0);
        pop_expect("par1_data", 8'h41);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        chk("par0_perr", 32'(parity_err), 32'd0);
        pop_expect("par0_data", 8'h41);

        // Short glitch in idle
        nbits = 4'd8; parity = c_PARITY_NONE;
        repeat (4) @(negedge clk);
        p0 = push_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("glitch_valid", 32'(valid), 32'd0);
        chk("glitch_push",  32'(push_cnt - p0), 32'd0);

        // Stop bit held low for 20 bit times
        p0 = push_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        repeat (19 * c_BIT) @(negedge clk);
        chk("brk_state", 32'(dut.state_q), 32'(S_BREAK));
        chk("brk_push",  32'(push_cnt - p0), 32'd1);
        chk("brk_ferr",  32'(frame_err), 32'd1);
        chk("brk_perr",  32'(parity_err), 32'd0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("brk_idle",   32'(dut.state_q), 32'(S_IDLE));
        chk("brk_push2",  32'(push_cnt - p0), 32'd1);
        pop_expect("brk_data", 8'h3C);
        chk("brk_empty", 32'(valid), 32'd0);

        // Five frames into a depth-4 FIFO with no consumer
        o0 = ovr_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        chk("fill2_rts", 32'(rts), 32'd1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
        chk("fill3_rts", 32'(rts), 32'd0);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1);
        chk("fill4_ovr", 32'(ovr_cnt - o0), 32'd0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        chk("fill5_ovr",   32'(ovr_cnt - o0), 32'd1);
        chk("fill5_count", 32'(dut.u_fifo.count_q), 32'd4);
        pop_expect("fifo_w1", 8'h11);
        pop_expect("fifo_w2", 8'h22);
        pop_expect("fifo_w3", 8'h33);
        pop_expect("fifo_w4", 8'h44);
        chk("fifo_empty", 32'(valid), 32'd0);
        chk("fifo_rts",   32'(rts),   32'd1);

        // Full FIFO, pop coincident with the stop-bit push
        send_frame(8'h61, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h62, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h63, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h64, 8, 1'b0, 1'b0, 1'b1);
        o0 = ovr_cnt;
        found = 1'b0;
        fork
            send_frame(8'h65, 8, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (dut.w_push === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        chk("sim_found", 32'(found), 32'd1);
        chk("sim_ovr",   32'(ovr_cnt - o0), 32'd0);
        chk("sim_count", 32'(dut.u_fifo.count_q), 32'd4);
        chk("sim_head",  32'(data), 32'h62);

        // Reset in the middle of a frame
        rx = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_rts",   32'(rts),   32'd1);
        chk("mrst_data",  32'(data),  32'd0);
        rst = 1'b1;
        p0 = push_cnt;
        repeat (300) @(negedge clk);
        chk("mrst_push",  32'(push_cnt - p0), 32'd0);
        chk("mrst_valid2", 32'(valid), 32'd0);
        chk("mrst_state", 32'(dut.state_q), 32'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
